// File: rtl/tdc_therm_capture.sv
// ---------------------------------------------------------------------------
// tdc_therm_capture
//
// Purpose:
//   Captures one snapshot of a TDC delay-line thermometer (meas_i) per arm
//   request, passes it through a two-flop metastability guard, encodes it
//   into a tap count and presents the result with a valid/ready handshake.
//
//   Sequence per measurement:
//     IDLE --arm_i--> CAP  (s1 <= meas_i)
//          --------> SYNC  (s2 <= s1)
//          --------> ENC   (code/ovf <= encode(s2), valid <= 1)
//          --------> HOLD  (wait for valid_o && ready_i)
//   A handshake in HOLD with arm_i high re-enters CAP directly, so
//   back-to-back measurements need no extra IDLE cycle.
//
// Configuration:
//   TDC_BUBBLE_CORR_EN  undefined (default): code = number of contiguous 1s
//                       starting at tap 0 (first 0 ends the count).
//                       defined: code = popcount of the synchronised taps,
//                       which tolerates isolated 0s (bubbles) below the edge.
//
// Parameters:
//   N       delay-line tap count (width of meas_i)
//   CODE_W  width of code_o, large enough to hold 0..N
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst          synchronous active-high reset
//   arm_i        request one capture (honoured in IDLE, or in HOLD together
//                with the handshake)
//   meas_i       raw thermometer taps, asynchronous to clk, bit 0 = first tap
//   code_o       encoded tap count, holds its value until the next ENC
//   valid_o      code_o / ovf_o are valid
//   ready_i      consumer accepts the result
//   ovf_o        the edge ran past the last tap (s2[N-1])
//   busy_o       high whenever the FSM is not in IDLE
//   state_dbg_o  current FSM state encoding, for observation only
//
// Handshake:
//   valid_o rises when a result is produced and then valid_o, code_o and
//   ovf_o stay frozen until a rising edge where valid_o && ready_i; on that
//   edge the result is consumed and valid_o falls. ready_i is ignored while
//   valid_o is low.
// ---------------------------------------------------------------------------
module tdc_therm_capture #(
  parameter int N      = 64,
  parameter int CODE_W = $clog2(N) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic [N-1:0]      meas_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              ovf_o,
  output logic              busy_o,
  output logic [2:0]        state_dbg_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAP  = 3'd1,
    SYNC = 3'd2,
    ENC  = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        s1_q, s1_d;
  logic [N-1:0]        s2_q, s2_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic [CODE_W-1:0]   enc_code;

  // -------------------------------------------------------------------------
  // Encoder: purely combinational on the synchronised sample s2.
  // -------------------------------------------------------------------------
`ifdef TDC_BUBBLE_CORR_EN
  // Popcount: every set tap counts, so a stray 0 below the edge does not
  // truncate the result.
  always_comb begin
    enc_code = '0;
    for (int i = 0; i < N; i++) begin
      enc_code = enc_code + CODE_W'(s2_q[i]);
    end
  end
`else
  // Leading-run count from tap 0: run_ones stays high only while every tap
  // seen so far was 1, so the first 0 stops further increments.
  logic run_ones;

  always_comb begin
    enc_code = '0;
    run_ones = 1'b1;
    for (int i = 0; i < N; i++) begin
      run_ones = run_ones & s2_q[i];
      enc_code = enc_code + CODE_W'(run_ones);
    end
  end
`endif

  // -------------------------------------------------------------------------
  // FSM next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = CAP;
        end
      end

      CAP: begin
        // First synchroniser stage samples the asynchronous taps.
        s1_d    = meas_i;
        state_d = SYNC;
      end

      SYNC: begin
        // Second stage: s2 is considered settled from here on.
        s2_d    = s1_q;
        state_d = ENC;
      end

      ENC: begin
        code_d  = enc_code;
        ovf_d   = s2_q[N-1];
        valid_d = 1'b1;
        state_d = HOLD;
      end

      HOLD: begin
        // code/ovf are left untouched here so they keep the last result
        // after the handshake until the next ENC overwrites them.
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          state_d = arm_i ? CAP : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers; reset wins over every other input.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign code_o      = code_q;
  assign ovf_o       = ovf_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != IDLE);
  assign state_dbg_o = state_q;

endmodule
